// File: rtl/tt_sweep_if.sv
// rtl/tt_sweep_if.sv - host/gate handshake bundle for the truth-table sweep controller
interface tt_sweep_if;
  logic       start;
  logic       abort;
  logic [2:0] gate_in;
  logic       gate_out;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       match;
  logic       glitch;

  // Sweep controller side
  modport slave (
    input  start, abort, gate_out,
    output gate_in, busy, done, result, match, glitch
  );

  // Host plus gate-under-test side
  modport master (
    output start, abort, gate_out,
    input  gate_in, busy, done, result, match, glitch
  );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// rtl/tt_sweep_ctrl.sv - sweeps a 3-input gate through all rows and captures its truth-table code
module tt_sweep_ctrl #(
  parameter logic [7:0] EXPECTED = 8'h08,
  parameter int         SETTLE   = 4
) (
  input  logic       clk,
  input  logic       reset,
  tt_sweep_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [2:0] row_q;
  logic [7:0] cnt_q;
  logic       last_out_q;
  logic [2:0] gate_in_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] result_q;
  logic       match_q;
  logic       glitch_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: abort beats every forward transition once a sweep is running
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (bus.abort)             state_d = ST_IDLE;
        else if (cnt_q == CNT_LAST) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (bus.abort)          state_d = ST_IDLE;
        else if (row_q == 3'd7) state_d = ST_DONE;
        else                    state_d = ST_SETTLE;
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath: row/settle counters, capture of gate_out and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q      <= 3'd0;
      cnt_q      <= 8'd0;
      last_out_q <= 1'b0;
      gate_in_q  <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 8'd0;
      match_q    <= 1'b0;
      glitch_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != ST_IDLE && bus.abort) begin
        busy_q    <= 1'b0;
        gate_in_q <= 3'd0;
        result_q  <= 8'd0;
        match_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.start) begin
              row_q     <= 3'd0;
              cnt_q     <= 8'd0;
              result_q  <= 8'd0;
              match_q   <= 1'b0;
              glitch_q  <= 1'b0;
              busy_q    <= 1'b1;
              gate_in_q <= 3'd0;
            end
          end
          ST_SETTLE: begin
            cnt_q      <= cnt_q + 8'd1;
            last_out_q <= bus.gate_out;
          end
          ST_SAMPLE: begin
            // Row k lands in bit 7-k so the code reads like the gate module names
            result_q[3'd7 - row_q] <= bus.gate_out;
            if (bus.gate_out != last_out_q) glitch_q <= 1'b1;
            if (row_q != 3'd7) begin
              row_q     <= row_q + 3'd1;
              cnt_q     <= 8'd0;
              gate_in_q <= row_q + 3'd1;
            end
          end
          ST_DONE: begin
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            match_q   <= (result_q == EXPECTED);
            gate_in_q <= 3'd0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.gate_in = gate_in_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.match   = match_q;
  assign bus.glitch  = glitch_q;

endmodule
